// File: rtl/dec3to8_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
// Used by decoder_3to8_reg and dec3to8_onehot_chk.
package dec3to8_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  function automatic onehot_t onehot_of(
    input sel_t sel
  );
    return onehot_t'(1) << sel;
  endfunction

  function automatic logic [3:0] popcount(
    input onehot_t v
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < OUT_W; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dec3to8_onehot_chk.sv
// Sticky invariant checker for the decoder register.
// Instantiated only when DEC3TO8_ONEHOT_CHECK_EN is defined.
module dec3to8_onehot_chk
  import dec3to8_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  input  onehot_t vec,
  output logic    err
);

  logic bad;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      valid:  bad = (popcount(vec) != 4'd1);
      !valid: bad = (vec != '0);
      default: bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bad) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/decoder_3to8_reg.sv
// Registered 3-to-8 one-hot decoder with optional output inversion.
// DEC3TO8_ONEHOT_CHECK_EN adds a sticky one-hot invariant flag (err).
module decoder_3to8_reg
  import dec3to8_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         b,
  input  logic         c,
  input  logic         en,
  output logic [7:0]   out,
`ifdef DEC3TO8_ONEHOT_CHECK_EN
  output logic         out_valid,
  output logic         err
`else
  output logic         out_valid
`endif
);

  sel_t    sel;
  onehot_t nxt_n;
  onehot_t out_n;

  assign sel = {a, b, c};

  always_comb begin
    nxt_n = '0;
    if (en) begin
      nxt_n = onehot_of(sel);
    end
  end

  // Disabled cycles clear the register rather than holding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_n     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_n     <= nxt_n;
      out_valid <= en;
    end
  end

  assign out = ACTIVE_LOW ? ~out_n : out_n;

`ifdef DEC3TO8_ONEHOT_CHECK_EN
  dec3to8_onehot_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .valid (out_valid),
    .vec   (out_n),
    .err   (err)
  );
`endif

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Self-checking bench for decoder_3to8_reg, both polarities.
// Reference model derives outputs from the select index arithmetically.
module tb_decoder_3to8_reg;

  logic       clk;
  logic       rst;
  logic       a, b, c, en;
  logic [7:0] out0, out1;
  logic       v0, v1;
`ifdef DEC3TO8_ONEHOT_CHECK_EN
  logic       err0, err1;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  logic [7:0] exp_n;
  logic       exp_v;

  decoder_3to8_reg #(.ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
    .out(out0),
`ifdef DEC3TO8_ONEHOT_CHECK_EN
    .out_valid(v0), .err(err0)
`else
    .out_valid(v0)
`endif
  );

  decoder_3to8_reg #(.ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .en(en),
    .out(out1),
`ifdef DEC3TO8_ONEHOT_CHECK_EN
    .out_valid(v1), .err(err1)
`else
    .out_valid(v1)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t",
               name, act, req, $time);
    end
  endtask

  // Reference: index value selects bit 2**index; disabled gives zero.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_n = 8'h00;
      exp_v = 1'b0;
    end else begin
      exp_v = en;
      exp_n = en ? 8'(2 ** (a * 4 + b * 2 + c)) : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_out_hi", out0, exp_n);
      check("model_out_lo", out1, ~exp_n);
      check("model_valid0", {7'd0, v0}, {7'd0, exp_v});
      check("model_valid1", {7'd0, v1}, {7'd0, exp_v});
`ifdef DEC3TO8_ONEHOT_CHECK_EN
      check("model_err0", {7'd0, err0}, 8'h00);
      check("model_err1", {7'd0, err1}, 8'h00);
`endif
    end
  end

  task automatic drive(input logic [2:0] s, input logic e);
    {a, b, c} = s;
    en = e;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] sweep [8];

  initial begin
    sweep = '{8'h01, 8'h02, 8'h04, 8'h08,
              8'h10, 8'h20, 8'h40, 8'h80};
    rst = 1;
    drive(3'd0, 1'b1);
    tick;
    tick;
    check("reset_out_hi", out0, 8'h00);
    check("reset_out_lo", out1, 8'hFF);
    check("reset_valid", {7'd0, v0}, 8'h00);
    rst = 0;
    chk_on = 1;

    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 1'b1);
      tick;
      check("sweep_out", out0, sweep[i]);
      check("sweep_valid", {7'd0, v0}, 8'h01);
    end

    drive(3'b101, 1'b1);
    tick;
    check("order_101", out0, 8'h20);
    drive(3'b011, 1'b1);
    tick;
    check("order_011", out0, 8'h08);

    drive(3'd6, 1'b0);
    tick;
    check("gate_off_out", out0, 8'h00);
    check("gate_off_valid", {7'd0, v0}, 8'h00);
    check("gate_off_low", out1, 8'hFF);
    drive(3'd6, 1'b1);
    tick;
    check("gate_on_out", out0, 8'h40);
    drive(3'd3, 1'b1);
    tick;
    check("low_sel3", out1, 8'hF7);

    repeat (300) begin
      drive(3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0));
      tick;
    end

    // Asynchronous reset between edges.
    drive(3'd5, 1'b1);
    tick;
    #1;
    rst = 1;
    #1;
    check("async_rst_hi", out0, 8'h00);
    check("async_rst_lo", out1, 8'hFF);
    check("async_rst_valid", {7'd0, v0}, 8'h00);
    drive(3'd7, 1'b1);
    tick;
    rst = 0;
    tick;
    check("release_decode", out0, 8'h80);
    check("release_valid", {7'd0, v0}, 8'h01);

`ifdef DEC3TO8_ONEHOT_CHECK_EN
    chk_on = 0;
    force u0.out_n = 8'h03;
    tick;
    check("err_set", {7'd0, err0}, 8'h01);
    release u0.out_n;
    tick;
    tick;
    check("err_sticky", {7'd0, err0}, 8'h01);
    check("err_other", {7'd0, err1}, 8'h00);
    rst = 1;
    #1;
    check("err_clear", {7'd0, err0}, 8'h00);
    tick;
    rst = 0;
    tick;
    check("err_after_rst", {7'd0, err0}, 8'h00);
`endif

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
